// File: rtl/banco_registradores.sv
// banco_registradores: 16 x 16-bit register file, two combinational read ports and one
// synchronous write port.
//
// Ports
//   clk        rising-edge clock for all register writes
//   reset      asynchronous, active-high; clears the whole array
//   regA       read address, port A
//   regB       read address, port B
//   regC       write address
//   RW         write enable, active-high
//   dado       write data
//   regsaidaA  read data, port A (R[regA])
//   regsaidaB  read data, port B (R[regB])
//
// Configuration
//   BANCO_REGISTRADORES_BYPASS_EN  when defined, a read port whose address matches regC
//                                  while RW=1 and reset=0 returns dado in the same cycle.
//                                  The stored array still updates only at the clock edge.
//                                  The port list is identical in both builds.

module banco_registradores (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  regA,
  input  logic [3:0]  regB,
  input  logic [3:0]  regC,
  input  logic        RW,
  input  logic [15:0] dado,
  output logic [15:0] regsaidaA,
  output logic [15:0] regsaidaB
);

  localparam int unsigned NumRegs = 16;
  localparam int unsigned Width   = 16;

  logic [Width-1:0] regs_q [NumRegs];

  // Register 0 is ordinary storage; every address is valid, so no range check.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (RW) begin
      regs_q[regC] <= dado;
    end
  end

  always_comb begin
    regsaidaA = regs_q[regA];
    regsaidaB = regs_q[regB];
`ifdef BANCO_REGISTRADORES_BYPASS_EN
    // Forward the pending write so a same-cycle read sees the new value.
    if (RW && !reset) begin
      if (regA == regC) begin
        regsaidaA = dado;
      end
      if (regB == regC) begin
        regsaidaB = dado;
      end
    end
`endif
    // The array is already cleared while reset is high; forcing zero here also keeps the
    // outputs clean in the instant reset rises.
    if (reset) begin
      regsaidaA = '0;
      regsaidaB = '0;
    end
  end

endmodule

// File: tb/tb_banco_registradores.sv
// Self-checking bench for banco_registradores: directed scenarios with literal
// expectations, then randomized traffic checked every half cycle against a behavioural
// model of the register file.

module tb_banco_registradores;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  regA, regB, regC;
  logic        RW;
  logic [15:0] dado;
  logic [15:0] regsaidaA, regsaidaB;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  logic [15:0] model [16];

  banco_registradores dut (
    .clk       (clk),
    .reset     (reset),
    .regA      (regA),
    .regB      (regB),
    .regC      (regC),
    .RW        (RW),
    .dado      (dado),
    .regsaidaA (regsaidaA),
    .regsaidaB (regsaidaB)
  );

  always #10 clk = ~clk;

  // Behavioural storage: writes land at the rising edge, reset clears immediately.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) model[i] <= 16'h0000;
    end else if (RW) begin
      model[regC] <= dado;
    end
  end

  function automatic logic [15:0] exp_rd(input logic [3:0] addr);
    if (reset) return 16'h0000;
`ifdef BANCO_REGISTRADORES_BYPASS_EN
    if (RW && addr == regC) return dado;
`endif
    return model[addr];
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Continuous compare, sampled 2 time units after each clock edge.
  always @(clk) begin
    #2;
    if (chk_en) begin
      check("model_portA", regsaidaA, exp_rd(regA));
      check("model_portB", regsaidaB, exp_rd(regB));
    end
  end

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic rw, input logic [15:0] d);
    @(negedge clk);
    regA = a;
    regB = b;
    regC = c;
    RW   = rw;
    dado = d;
  endtask

  // Reset pulse placed between edges, clear of the compare sample points.
  task automatic reset_pulse();
    #3 reset = 1'b1;
    #1;
    check("rst_read_A", regsaidaA, 16'h0000);
    check("rst_read_B", regsaidaB, 16'h0000);
    #1 reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    reset = 1'b1;
    regA  = '0;
    regB  = '0;
    regC  = '0;
    RW    = 1'b0;
    dado  = '0;
    repeat (2) @(negedge clk);
    check("init_reset_A", regsaidaA, 16'h0000);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Fill every register so the reset pulse has something to clear.
    for (int i = 0; i < 16; i++) drive(4'(i), 4'(i), 4'(i), 1'b1, 16'(i * 16'h1111 + 1));
    drive(4'd3, 4'd12, 4'd0, 1'b0, 16'h0000);
    #1 check("prefill_R3", regsaidaA, 16'h3334);
    reset_pulse();
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 4'(15 - i), 4'd0, 1'b0, 16'hFFFF);
      #1;
      check("sweep_zero_A", regsaidaA, 16'h0000);
      check("sweep_zero_B", regsaidaB, 16'h0000);
    end

    // Writes on successive edges, then dual read.
    drive(4'd0, 4'd0, 4'd3, 1'b1, 16'hBEEF);
    drive(4'd0, 4'd0, 4'd12, 1'b1, 16'h1234);
    drive(4'd3, 4'd12, 4'd0, 1'b0, 16'h0000);
    #1;
    check("wr_R3", regsaidaA, 16'hBEEF);
    check("wr_R12", regsaidaB, 16'h1234);
    for (int i = 0; i < 16; i++) begin
      if (i != 3 && i != 12) begin
        drive(4'(i), 4'(i), 4'd0, 1'b0, 16'h0000);
        #1 check("others_zero", regsaidaA, 16'h0000);
      end
    end

    // Write enable low: R3 must hold.
    drive(4'd3, 4'd3, 4'd3, 1'b0, 16'hFFFF);
    @(posedge clk);
    #1 check("we_low_R3", regsaidaA, 16'hBEEF);

    // Same-cycle read of the write target.
    drive(4'd5, 4'd0, 4'd5, 1'b1, 16'hA5A5);
    #1;
`ifdef BANCO_REGISTRADORES_BYPASS_EN
    check("pre_edge_R5", regsaidaA, 16'hA5A5);
`else
    check("pre_edge_R5", regsaidaA, 16'h0000);
`endif
    @(posedge clk);
    #1 check("post_edge_R5", regsaidaA, 16'hA5A5);

    // Mid-operation reset with a pending write.
    drive(4'd7, 4'd5, 4'd7, 1'b1, 16'h0042);
    drive(4'd7, 4'd5, 4'd7, 1'b1, 16'h1111);
    #1 check("R7_written", regsaidaA, 16'h0042);
    #2 reset = 1'b1;
    #1 check("R7_async_clr", regsaidaA, 16'h0000);
    @(posedge clk);
    #1 check("R7_clk_in_rst", regsaidaA, 16'h0000);
    drive(4'd7, 4'd5, 4'd7, 1'b0, 16'h0000);
    reset = 1'b0;
    #1;
    check("R7_after_rel", regsaidaA, 16'h0000);
    check("R5_after_rel", regsaidaB, 16'h0000);

    // Release and dual-port read of R0.
    drive(4'd0, 4'd0, 4'd0, 1'b1, 16'h0001);
    @(posedge clk);
    #1;
    check("R0_portA", regsaidaA, 16'h0001);
    check("R0_portB", regsaidaB, 16'h0001);

    // Randomized traffic; occasional asynchronous reset pulses.
    for (int n = 0; n < 3000; n++) begin
      drive(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)),
            1'($urandom_range(1)), 16'($urandom));
      if ($urandom_range(99) == 0) reset_pulse();
    end

    drive(4'd0, 4'd0, 4'd0, 1'b0, 16'h0000);
    @(negedge clk);
    chk_en = 1'b0;
    #5;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
